// File: rtl/adc_spi_scan.sv
// SPI master that scans the enabled channels of an ADC128S022-class converter,
// pipelining each channel address one frame ahead of its returned sample.
module adc_spi_scan #(
  parameter int CLK_DIV    = 2,
  parameter int FRAME_BITS = 16,
  parameter int DATA_BITS  = 12,
  parameter int NUM_CH     = 8,
  parameter int ADDR_MSB   = 13,
  parameter int CS_HIGH    = 4,
  localparam int CH_BITS   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 cont,
  input  logic [NUM_CH-1:0]    ch_mask,
  output logic                 busy,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 din,
  input  logic                 dout,
  output logic [DATA_BITS-1:0] data,
  output logic [CH_BITS-1:0]   data_ch,
  output logic                 data_valid
);

  // state | meaning
  // IDLE  | waiting for a start edge with a non-empty mask
  // SETUP | cs_n low, sclk high for CLK_DIV cycles before the first falling edge
  // SHIFT | back-to-back frames, one SCLK period per bit
  // GAP   | cs_n high for CS_HIGH cycles, then rescan (cont) or idle
  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  localparam int DIV_W    = $clog2(CLK_DIV) + 1;
  localparam int BIT_W    = $clog2(FRAME_BITS) + 1;
  localparam int GAP_W    = $clog2(CS_HIGH) + 1;
  localparam int ADDR_LSB = ADDR_MSB - CH_BITS + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH - 1);

  state_t                state;
  logic [1:0]            start_q;
  logic [NUM_CH-1:0]     mask;
  logic [NUM_CH-1:0]     pend;
  logic [FRAME_BITS-1:0] tx;
  logic [DATA_BITS-1:0]  rx;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [CH_BITS-1:0]    send_ch;
  logic [CH_BITS-1:0]    ret_ch;
  logic                  ret_ok;
  logic                  last;

  logic                  start_edge;
  logic [CH_BITS-1:0]    nxt_ch;
  logic                  nxt_has;
  logic [NUM_CH-1:0]     sel;
  logic [FRAME_BITS-1:0] tx_load;
  logic [DATA_BITS-1:0]  rx_next;

  assign start_edge = start_q[0] & ~start_q[1];
  assign rx_next    = {rx[DATA_BITS-2:0], dout};
  assign tx_load    = FRAME_BITS'(nxt_ch) << ADDR_LSB;

  // Lowest still-pending channel; an empty set yields address 0 for the flush frame.
  always_comb begin
    nxt_ch  = '0;
    nxt_has = 1'b0;
    sel     = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (pend[i]) begin
        nxt_ch  = CH_BITS'(i);
        nxt_has = 1'b1;
        sel     = '0;
        sel[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start_q    <= '0;
      mask       <= '0;
      pend       <= '0;
      tx         <= '0;
      rx         <= '0;
      div_cnt    <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      send_ch    <= '0;
      ret_ch     <= '0;
      ret_ok     <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
      sclk       <= 1'b1;
      cs_n       <= 1'b1;
      din        <= 1'b0;
      data       <= '0;
      data_ch    <= '0;
      data_valid <= 1'b0;
    end else begin
      start_q    <= {start_q[0], start};
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start_edge && ch_mask != '0) begin
            mask    <= ch_mask;
            pend    <= ch_mask;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            div_cnt <= DIV_LAST;
            state   <= SETUP;
          end
        end
        SETUP: begin
          if (div_cnt == '0) begin
            sclk    <= 1'b0;
            div_cnt <= DIV_LAST;
            bit_cnt <= BIT_LAST;
            din     <= tx_load[FRAME_BITS-1];
            tx      <= tx_load << 1;
            pend    <= pend & ~sel;
            send_ch <= nxt_ch;
            last    <= ~nxt_has;
            ret_ok  <= 1'b0;
            state   <= SHIFT;
          end else begin
            div_cnt <= div_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (div_cnt != '0) begin
            div_cnt <= div_cnt - 1'b1;
          end else begin
            div_cnt <= DIV_LAST;
            if (!sclk) begin
              sclk <= 1'b1;
              rx   <= rx_next;
              if (bit_cnt == '0 && ret_ok) begin
                data       <= rx_next;
                data_ch    <= ret_ch;
                data_valid <= 1'b1;
              end
            end else if (bit_cnt != '0) begin
              sclk    <= 1'b0;
              din     <= tx[FRAME_BITS-1];
              tx      <= tx << 1;
              bit_cnt <= bit_cnt - 1'b1;
            end else if (last) begin
              cs_n    <= 1'b1;
              gap_cnt <= GAP_LAST;
              state   <= GAP;
            end else begin
              // Next frame returns the channel addressed by the one just finished.
              sclk    <= 1'b0;
              bit_cnt <= BIT_LAST;
              din     <= tx_load[FRAME_BITS-1];
              tx      <= tx_load << 1;
              pend    <= pend & ~sel;
              send_ch <= nxt_ch;
              last    <= ~nxt_has;
              ret_ch  <= send_ch;
              ret_ok  <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else if (cont) begin
            cs_n    <= 1'b0;
            pend    <= mask;
            div_cnt <= DIV_LAST;
            state   <= SETUP;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
